// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu
//  Purpose  : E-stage multiply/divide unit with fixed multi-cycle latency.
//             Owns the HI/LO registers, serves mfhi/mflo combinationally,
//             and ignores any start or move presented under a flush request.
//  Revision : 1.0  initial release
// ============================================================================
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_MDOp,
   input  logic        E_Start,
   input  logic [31:0] E_RS,
   input  logic [31:0] E_RT,
   input  logic        Req,
   output logic [31:0] E_MDData,
   output logic        E_Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
   localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

   logic [0:0]  busy_q;
   logic [3:0]  cnt;
   logic [31:0] hi_tmp;
   logic [31:0] lo_tmp;

   logic        is_md_op;
   logic        accept;
   logic [31:0] res_hi;
   logic [31:0] res_lo;
   logic [3:0]  res_cycles;

   // Signed/unsigned products and quotients. Signed division works on
   // magnitudes so that 0x80000000 / -1 is well defined (wraps to 0x80000000).
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] abs_rs;
   logic [31:0] abs_rt;
   logic [31:0] div_by;
   logic [31:0] sdiv_by;
   logic [31:0] uq_s;
   logic [31:0] ur_s;
   logic [31:0] q_u;
   logic [31:0] r_u;

   assign is_md_op = (E_MDOp >= OP_MULT) && (E_MDOp <= OP_DIVU);
   assign accept   = (busy_q == ST_IDLE) && !Req && E_Start && is_md_op;
   assign E_Busy   = (busy_q == ST_BUSY) || (E_Start && is_md_op);

   // Read port for mfhi/mflo; any other op reads zero.
   always_comb begin
      E_MDData = 32'd0;
      if (E_MDOp == OP_MFHI) E_MDData = HI;
      else if (E_MDOp == OP_MFLO) E_MDData = LO;
   end

   // Arithmetic datapath: result and latency for the op being presented.
   always_comb begin
      prod_s  = {{32{E_RS[31]}}, E_RS} * {{32{E_RT[31]}}, E_RT};
      prod_u  = {32'd0, E_RS} * {32'd0, E_RT};
      abs_rs  = E_RS[31] ? (~E_RS + 32'd1) : E_RS;
      abs_rt  = E_RT[31] ? (~E_RT + 32'd1) : E_RT;
      div_by  = (E_RT == 32'd0) ? 32'd1 : E_RT;
      sdiv_by = (abs_rt == 32'd0) ? 32'd1 : abs_rt;
      uq_s    = abs_rs / sdiv_by;
      ur_s    = abs_rs % sdiv_by;
      q_u     = E_RS / div_by;
      r_u     = E_RS % div_by;

      res_hi     = HI;
      res_lo     = LO;
      res_cycles = MULT_N;
      case (E_MDOp)
         OP_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         OP_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         OP_DIV: begin
            res_cycles = DIV_N;
            // A zero divisor recommits the current HI/LO, i.e. no change.
            if (E_RT != 32'd0) begin
               res_lo = (E_RS[31] ^ E_RT[31]) ? (~uq_s + 32'd1) : uq_s;
               res_hi = E_RS[31] ? (~ur_s + 32'd1) : ur_s;
            end
         end
         OP_DIVU: begin
            res_cycles = DIV_N;
            if (E_RT != 32'd0) begin
               res_lo = q_u;
               res_hi = r_u;
            end
         end
         default: ;
      endcase
   end

   // IDLE/BUSY control, HI/LO writes (mthi/mtlo and commit), countdown.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= ST_IDLE;
         cnt    <= 4'd0;
         hi_tmp <= 32'd0;
         lo_tmp <= 32'd0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else if (busy_q == ST_IDLE) begin
         cnt <= 4'd0;
         if (accept) begin
            busy_q <= ST_BUSY;
            cnt    <= res_cycles;
            hi_tmp <= res_hi;
            lo_tmp <= res_lo;
         end else if (!Req && (E_MDOp == OP_MTHI)) begin
            HI <= E_RS;
         end else if (!Req && (E_MDOp == OP_MTLO)) begin
            LO <= E_RS;
         end
      end else begin
         if (cnt <= 4'd1) begin
            HI     <= hi_tmp;
            LO     <= lo_tmp;
            busy_q <= ST_IDLE;
            cnt    <= 4'd0;
         end else begin
            cnt <= cnt - 4'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu
//  Purpose  : Directed self-checking bench for e_mdu with a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_e_mdu;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic [3:0]  E_MDOp;
   logic        E_Start;
   logic [31:0] E_RS;
   logic [31:0] E_RT;
   logic        Req;
   logic [31:0] E_MDData;
   logic        E_Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   res_t        sb[$];
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk      (clk),
      .reset    (reset),
      .E_MDOp   (E_MDOp),
      .E_Start  (E_Start),
      .E_RS     (E_RS),
      .E_RT     (E_RT),
      .Req      (Req),
      .E_MDData (E_MDData),
      .E_Busy   (E_Busy),
      .HI       (HI),
      .LO       (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present one cycle's inputs at the falling edge, settle, then return.
   task automatic drive(input logic [3:0] op, input logic st, input logic [31:0] rs,
                        input logic [31:0] rt, input logic rq);
      @(negedge clk);
      E_MDOp  = op;
      E_Start = st;
      E_RS    = rs;
      E_RT    = rt;
      Req     = rq;
      #1;
   endtask

   task automatic idle();
      drive(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   // Reference model of the architectural result.
   function automatic res_t model(input logic [3:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [31:0] hi,
                                  input logic [31:0] lo);
      res_t        r;
      longint      a, b, q, m;
      logic [63:0] p;
      r.hi = hi;
      r.lo = lo;
      case (op)
         4'd1: begin
            p = longint'($signed(rs)) * longint'($signed(rt));
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         4'd2: begin
            p = {32'd0, rs} * {32'd0, rt};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         4'd3: if (rt != 32'd0) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
            q = a / b;
            m = a % b;
            r.lo = q[31:0];
            r.hi = m[31:0];
         end
         4'd4: if (rt != 32'd0) begin
            r.lo = rs / rt;
            r.hi = rs % rt;
         end
         default: ;
      endcase
      return r;
   endfunction

   // Launch an MD op, count busy cycles, then read back via mfhi/mflo.
   task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input int n);
      res_t exp;
      int   busy_cycles;
      drive(op, 1'b1, rs, rt, 1'b0);
      chk({tag, "_busy_c0"}, {31'd0, E_Busy}, 32'd1);
      sb.push_back(model(op, rs, rt, m_hi, m_lo));
      busy_cycles = 0;
      idle();
      while (E_Busy && busy_cycles < 40) begin
         busy_cycles++;
         idle();
      end
      chk({tag, "_busy_len"}, busy_cycles, n);
      exp = sb.pop_front();
      drive(4'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      chk({tag, "_mfhi"}, E_MDData, exp.hi);
      drive(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
      chk({tag, "_mflo"}, E_MDData, exp.lo);
      chk({tag, "_hi"}, HI, exp.hi);
      m_hi = exp.hi;
      m_lo = exp.lo;
   endtask

   initial begin
      reset   = 1'b0;
      E_MDOp  = 4'd0;
      E_Start = 1'b0;
      E_RS    = 32'd0;
      E_RT    = 32'd0;
      Req     = 1'b0;
      #12;
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      drive(4'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("rst_mfhi", E_MDData, 32'd0);
      chk("rst_busy", {31'd0, E_Busy}, 32'd0);
      drive(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("rst_mflo", E_MDData, 32'd0);

      run_md("mult",   4'd1, 32'hFFFF_FFFE, 32'd3, MC);
      run_md("multu",  4'd2, 32'hFFFF_FFFE, 32'd3, MC);
      run_md("div",    4'd3, 32'hFFFF_FFF9, 32'd2, DC);
      run_md("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC);
      run_md("divu",   4'd4, 32'd100, 32'd7, DC);
      run_md("divu0",  4'd4, 32'd7, 32'd0, DC);
      run_md("div0",   4'd3, 32'hFFFF_FFF9, 32'd0, DC);

      // mthi/mtlo, then a flushed mthi must leave HI alone.
      drive(4'd7, 1'b0, 32'h1234_5678, 32'd0, 1'b0);
      drive(4'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mthi", E_MDData, 32'h1234_5678);
      drive(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mthi_lo_kept", E_MDData, m_lo);
      m_hi = 32'h1234_5678;
      drive(4'd8, 1'b1, 32'hCAFE_F00D, 32'd0, 1'b0);
      drive(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mtlo", E_MDData, 32'hCAFE_F00D);
      m_lo = 32'hCAFE_F00D;
      drive(4'd7, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1);
      drive(4'd5, 1'b0, 32'd0, 32'd0, 1'b0);
      chk("mthi_req", E_MDData, 32'h1234_5678);

      // Start under flush: no busy afterwards, nothing committed.
      drive(4'd1, 1'b1, 32'd5, 32'd6, 1'b1);
      idle();
      chk("req_start_busy", {31'd0, E_Busy}, 32'd0);
      repeat (MC + 1) idle();
      chk("req_start_hi", HI, m_hi);
      chk("req_start_lo", LO, m_lo);

      // In-flight mult survives a later flush; second start and mtlo ignored.
      drive(4'd1, 1'b1, 32'd7, 32'd9, 1'b0);
      sb.push_back(model(4'd1, 32'd7, 32'd9, m_hi, m_lo));
      drive(4'd3, 1'b1, 32'd100, 32'd3, 1'b0);
      chk("inflt_busy_c1", {31'd0, E_Busy}, 32'd1);
      drive(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      drive(4'd8, 1'b0, 32'hAAAA_5555, 32'd0, 1'b0);
      idle();
      idle();
      chk("inflt_busy_c5", {31'd0, E_Busy}, 32'd1);
      chk("inflt_lo_c5", LO, m_lo);
      begin
         res_t exp;
         exp = sb.pop_front();
         drive(4'd5, 1'b0, 32'd0, 32'd0, 1'b0);
         chk("inflt_busy_c6", {31'd0, E_Busy}, 32'd0);
         chk("inflt_hi", E_MDData, exp.hi);
         drive(4'd6, 1'b0, 32'd0, 32'd0, 1'b0);
         chk("inflt_lo", E_MDData, exp.lo);
         m_hi = exp.hi;
         m_lo = exp.lo;
      end
      repeat (DC + 2) idle();
      chk("inflt_no_second_lo", LO, m_lo);

      // Reset mid-divide aborts: immediate clear, no later commit.
      drive(4'd4, 1'b1, 32'd100, 32'd7, 1'b0);
      idle();
      idle();
      idle();
      @(negedge clk);
      E_MDOp  = 4'd0;
      E_Start = 1'b0;
      reset   = 1'b0;
      #1;
      chk("abort_hi", HI, 32'd0);
      chk("abort_lo", LO, 32'd0);
      chk("abort_busy", {31'd0, E_Busy}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (DC + 5) idle();
      chk("abort_post_hi", HI, 32'd0);
      chk("abort_post_lo", LO, 32'd0);
      chk("abort_post_busy", {31'd0, E_Busy}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency and owns the HI/LO registers.
- Serves mfhi/mflo combinationally as E_MDData, which E_MRegister latches into the M stage.
- Drives E_Busy to the hazard unit so that later MD instructions stall in E.
- Honours Req (exception/interrupt flush) so that a flushed E instruction never changes HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- E_MDOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- E_Start  input  1  qualifies ops 1..4 for the current E instruction.
- E_RS  input  32  forwarded rs value: dividend/multiplicand, or mthi/mtlo source.
- E_RT  input  32  forwarded rt value: divisor/multiplier.
- Req  input  1  exception/interrupt request from CP0; the E instruction is being flushed.
- E_MDData  output  32  HI when op=5, LO when op=6, else 0 (combinational).
- E_Busy  output  1  busy_q OR (E_Start AND op in 1..4).
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- States are IDLE and BUSY. Internal state: busy_q, 4-bit cnt, 32-bit hi_tmp and lo_tmp.
- Reset (reset=0, asynchronous): HI=0, LO=0, hi_tmp=0, lo_tmp=0, cnt=0, busy_q=0. Outputs follow immediately: E_MDData=0 unless op=5/6 selects the zero HI/LO, E_Busy=E_Start-qualified term only.
- Accept condition, at the rising edge: state IDLE, Req=0, E_Start=1, op in 1..4. The sources are then sampled. The result is computed and stored into hi_tmp/lo_tmp at that edge. The unit enters BUSY with cnt=N, where N=MULT_CYCLES for ops 1/2 and DIV_CYCLES for ops 3/4.
- BUSY timing, with the accept edge at cycle 0:
  - busy_q=1 during cycles 1..N; cnt decrements each edge.
  - At the edge ending cycle N (cnt==1): HI<=hi_tmp, LO<=lo_tmp, busy_q<=0, state IDLE.
  - mfhi/mflo therefore see the new values from cycle N+1.
- mult: {HI,LO} = signed 64-bit product. multu: unsigned 64-bit product.
- div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divisor = 0 (div/divu): the operation is still accepted and still busy for N cycles, but HI/LO are left unchanged at completion.
- mthi/mtlo: when Req=0 and state IDLE, HI (op 7) or LO (op 8) <= E_RS at the edge. These ops ignore E_Start.
- E_Start or mthi/mtlo while BUSY: ignored. The hazard unit guarantees this cannot happen; the unit must still not corrupt state if it does.
- Req=1 at an edge: any start or mthi/mtlo presented that cycle is ignored. An operation already in flight continues and commits normally, since a restarted instruction recomputes the same result.
- Op 5/6 while BUSY: E_MDData returns the old HI/LO. The stall guarantees the value is never consumed.
- cnt never wraps: it is held at 0 in IDLE.
- Asserting reset mid-operation aborts the operation. HI/LO go to 0 and no commit occurs.

Test Plan:
- Reset release, op=5 then op=6 -> E_MDData=0 both; E_Busy=0; HI=LO=0.
- mult, RS=0xFFFFFFFE (-2), RT=3, start at cycle 0 -> E_Busy=1 in cycles 0..5; cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x2, LO=0xFFFFFFFA.
- div, RS=-7 (0xFFFFFFF9), RT=2 -> busy for cycles 1..10; after commit LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. divu 7/0 -> HI/LO unchanged.
- mthi RS=0x12345678 then mflo/mfhi -> E_MDData=0x12345678 on op=5 the next cycle. mthi with Req=1 -> HI unchanged.
- Start mult with Req=1 -> no BUSY, HI/LO unchanged. Start mult, then Req=1 in cycle 2 -> still commits at cycle 5 edge; a second start during cycles 1..5 is ignored.
- Start divu 100/7, drive reset=0 in cycle 4 -> immediate HI=LO=0, E_Busy=0; after release no commit ever appears.
